cu_seq: RTL and testbench

Sequenced, parametrised control unit for the autoencoder datapath. It accepts one instruction per handshake and decodes the opcode into registered datapath enables. It then repeats the operation over `rep_cnt+1` consecutive memory elements with an auto-incrementing address, stretching multiplications to the multiplier latency. It sits between the instruction source (host FSM / instruction memory) and the ALU, memory and activation-LUT datapath.

---
 rtl/cu_seq.sv | 174 +++++++++++++++++
 tb/tb_cu_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cu_seq.sv
// Sequenced control unit: decodes one instruction per handshake into registered
// datapath enables, repeated over rep_cnt+1 elements. Optional trap: CU_SEQ_TRAP_EN.
module cu_seq #(
    parameter int OP_WIDTH   = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MUL_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [OP_WIDTH-1:0]   opcode,
    input  logic [CNT_WIDTH-1:0]  rep_cnt,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  en_writeMem,
    output logic                  en_alu,
    output logic                  en_selMem,
    output logic                  oprnd2_sel,
    output logic [1:0]            op_sel,
    output logic [1:0]            dest_control,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal_op
);

    localparam int SUB_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [SUB_W-1:0] MUL_LAST = SUB_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC
`ifdef CU_SEQ_TRAP_EN
        , HALT
`endif
    } state_t;

    typedef struct packed {
        logic       en_writeMem;
        logic       en_alu;
        logic       en_selMem;
        logic       oprnd2_sel;
        logic [1:0] op_sel;
        logic [1:0] dest_control;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [2:0] op, input logic last_sub);
        ctrl_t c;
        c = '0;
        case (op)
            3'd0: begin c.en_alu = 1'b1; c.en_writeMem = 1'b1; end
            3'd1: begin c.en_alu = 1'b1; c.en_writeMem = 1'b1; c.op_sel = 2'b01; end
            3'd2: begin c.en_alu = 1'b1; c.op_sel = 2'b10; c.en_writeMem = last_sub; end
            3'd3: c.en_writeMem = 1'b1;
            3'd4: c.en_selMem = 1'b1;
            3'd5: begin c.dest_control = 2'b01; c.en_writeMem = 1'b1; c.oprnd2_sel = 1'b1; end
            3'd6: begin c.dest_control = 2'b10; c.en_writeMem = 1'b1; c.oprnd2_sel = 1'b1; end
            default: begin c.dest_control = 2'b11; c.en_writeMem = 1'b1; c.oprnd2_sel = 1'b1; end
        endcase
        return c;
    endfunction

    state_t               state;
    ctrl_t                ctrl_q;
    logic [2:0]           op_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [SUB_W-1:0]     sub_q;
    logic [SUB_W-1:0]     sub_last_q;

    logic       upper_zero, is_exec, is_nop, accept, first_last;
    logic [3:0] lo;
    logic [SUB_W-1:0] sub_nxt;

    assign lo         = opcode[3:0];
    assign upper_zero = ((opcode >> 4) == '0);
    assign is_exec    = upper_zero && !lo[3];
    assign is_nop     = upper_zero && (lo == 4'hF);
    assign accept     = instr_valid && instr_ready;
    // A single-cycle element is its own last sub-cycle.
    assign first_last = (lo[2:0] != 3'd2) || (MUL_LAT == 1);
    assign sub_nxt    = sub_q + SUB_W'(1);

    assign en_writeMem  = ctrl_q.en_writeMem;
    assign en_alu       = ctrl_q.en_alu;
    assign en_selMem    = ctrl_q.en_selMem;
    assign oprnd2_sel   = ctrl_q.oprnd2_sel;
    assign op_sel       = ctrl_q.op_sel;
    assign dest_control = ctrl_q.dest_control;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal_op  <= 1'b0;
            ctrl_q      <= '0;
            addr        <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            sub_q       <= '0;
            sub_last_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    illegal_op  <= 1'b0;
                    ctrl_q      <= '0;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                    if (accept) begin
                        instr_ready <= 1'b0;
                        if (is_exec) begin
                            state      <= EXEC;
                            busy       <= 1'b1;
                            op_q       <= lo[2:0];
                            cnt_q      <= rep_cnt;
                            addr       <= base_addr;
                            sub_q      <= '0;
                            sub_last_q <= (lo[2:0] == 3'd2) ? MUL_LAST : '0;
                            ctrl_q     <= decode(lo[2:0], first_last);
                            done       <= first_last && (rep_cnt == '0);
                        end else if (is_nop) begin
                            done <= 1'b1;
                        end else begin
`ifdef CU_SEQ_TRAP_EN
                            state      <= HALT;
                            busy       <= 1'b1;
                            illegal_op <= 1'b1;
`else
                            done       <= 1'b1;
                            illegal_op <= 1'b1;
`endif
                        end
                    end
                end
                EXEC: begin
                    if (sub_q == sub_last_q) begin
                        if (cnt_q == '0) begin
                            state       <= IDLE;
                            ctrl_q      <= '0;
                            done        <= 1'b0;
                            busy        <= 1'b0;
                            instr_ready <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q - CNT_WIDTH'(1);
                            addr   <= addr + ADDR_WIDTH'(1);
                            sub_q  <= '0;
                            ctrl_q <= decode(op_q, sub_last_q == '0);
                            done   <= (cnt_q == CNT_WIDTH'(1)) && (sub_last_q == '0);
                        end
                    end else begin
                        sub_q  <= sub_nxt;
                        ctrl_q <= decode(op_q, sub_nxt == sub_last_q);
                        done   <= (cnt_q == '0) && (sub_nxt == sub_last_q);
                    end
                end
`ifdef CU_SEQ_TRAP_EN
                HALT: begin
                    // Parked until reset; nothing further is accepted.
                    illegal_op  <= 1'b1;
                    busy        <= 1'b1;
                    instr_ready <= 1'b0;
                    done        <= 1'b0;
                    ctrl_q      <= '0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_seq.sv
// Self-checking bench for cu_seq (default build): directed steps plus random
// instructions checked against a per-cycle trace model.
module tb_cu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] opcode = '0;
    logic [7:0] rep_cnt = '0;
    logic [7:0] base_addr = '0;
    logic       en_writeMem, en_alu, en_selMem, oprnd2_sel;
    logic [1:0] op_sel, dest_control;
    logic [7:0] addr;
    logic       busy, done, illegal_op;

    int total = 0;
    int bad   = 0;

    cu_seq #(.OP_WIDTH(4), .CNT_WIDTH(8), .ADDR_WIDTH(8), .MUL_LAT(3)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rep_cnt(rep_cnt), .base_addr(base_addr),
        .en_writeMem(en_writeMem), .en_alu(en_alu), .en_selMem(en_selMem),
        .oprnd2_sel(oprnd2_sel), .op_sel(op_sel), .dest_control(dest_control),
        .addr(addr), .busy(busy), .done(done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // {wr, alu, selMem, oprnd2, op_sel, dest, busy, done, illegal, ready}
    wire [11:0] obs_v = {en_writeMem, en_alu, en_selMem, oprnd2_sel, op_sel,
                         dest_control, busy, done, illegal_op, instr_ready};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one EXEC cycle of operation o.
    function automatic logic [11:0] model(input int o, input bit last_sub, input bit last_elem);
        logic wr, alu, sel, o2;
        logic [1:0] ops, dst;
        wr  = (o == 0 || o == 1 || o == 3 || (o >= 5 && o <= 7)) || (o == 2 && last_sub);
        alu = (o <= 2);
        sel = (o == 4);
        o2  = (o >= 5 && o <= 7);
        ops = (o == 1) ? 2'd1 : (o == 2) ? 2'd2 : 2'd0;
        dst = o2 ? 2'(o - 4) : 2'd0;
        return {wr, alu, sel, o2, ops, dst, 1'b1, last_elem && last_sub, 1'b0, 1'b0};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", instr_ready, 1);
    endtask

    task automatic issue(input int o, input int r, input int b);
        int len;
        bit first;
        wait_ready();
        opcode = 4'(o); rep_cnt = 8'(r); base_addr = 8'(b); instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        if (o <= 7) begin
            len = (o == 2) ? 3 : 1;
            first = 1'b1;
            for (int e = 0; e <= r; e++) begin
                for (int s = 0; s < len; s++) begin
                    if (!first) @(negedge clk);
                    first = 1'b0;
                    chk($sformatf("op%0d_e%0d_s%0d", o, e, s), obs_v, model(o, s == len - 1, e == r));
                    chk($sformatf("op%0d_addr%0d", o, e), addr, (b + e) % 256);
                end
            end
        end else begin
            // NOP/illegal: a lone done pulse, illegal flagged for 8..14
            chk($sformatf("op%0d_pulse", o), obs_v[11:1], {9'b0, 1'b1, o != 15});
        end
        @(negedge clk);
        chk($sformatf("op%0d_idle", o), obs_v, 12'h001);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", obs_v, 12'h001);
        chk("reset_addr", addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of a mul
        wait_ready();
        opcode = 4'd2; rep_cnt = 8'd3; base_addr = 8'h40; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_outs", obs_v, 12'h001);
        chk("mid_rst_addr", addr, 0);
        @(negedge clk);
        chk("mid_rst_nodone", obs_v, 12'h001);

        issue(0, 2, 8'h10);
        issue(2, 1, 8'h00);
        issue(6, 1, 8'hFF);

        // sigmoid then NOP with instr_valid held high
        wait_ready();
        opcode = 4'd5; rep_cnt = 8'd0; base_addr = 8'h22; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_sig", obs_v, model(5, 1'b1, 1'b1));
        opcode = 4'd15;
        @(negedge clk);
        chk("b2b_ready", instr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_nop", obs_v[11:1], 11'b000_0000_0010);
        @(negedge clk);
        chk("b2b_idle", obs_v, 12'h001);

        issue(9, 0, 0);
        issue(15, 3, 8'h80);
        issue(1, 0, 8'h7F);
        issue(4, 2, 8'hFE);

        for (int i = 0; i < 25; i++)
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
